// File: rtl/lc3b_types.sv
`default_nettype none
// ============================================================================
// Module      : lc3b_types (package)
// Description : Shared types and default geometry for the cache line array.
// Revision    : 1.0 - initial release
// ============================================================================
package lc3b_types;

    localparam int c_WIDTH = 128;              // default data bits per entry
    localparam int c_DEPTH = 8;                // default number of entries
    localparam int c_IW    = $clog2(c_DEPTH);  // default index width

    // Entry index for the default geometry
    typedef logic [c_IW-1:0] lc3b_index;

    // Sweep controller state encoding
    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_SWEEP = 1'b1;

endpackage
`default_nettype wire

// File: rtl/array_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : array_sweep_ctrl
// Description : Invalidate-all sweep FSM. Walks a pointer over every entry,
//               one entry per cycle, and flags busy while walking.
// Revision    : 1.0 - initial release
// ============================================================================
module array_sweep_ctrl
    import lc3b_types::*;
#(
    parameter  int DEPTH = c_DEPTH,
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    output logic          busy,
    output logic [IW-1:0] ptr
);

    logic [0:0]    r_state;
    logic [0:0]    w_state_nxt;
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_ptr_nxt;

    // State and pointer registers; reset aborts any sweep in progress
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Next state: flush starts at entry 0, last entry returns to idle
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            c_ST_IDLE: begin
                if (flush) begin
                    w_state_nxt = c_ST_SWEEP;
                    w_ptr_nxt   = '0;
                end
            end
            c_ST_SWEEP: begin
                if (r_ptr == IW'(DEPTH - 1)) begin
                    w_state_nxt = c_ST_IDLE;
                    w_ptr_nxt   = '0;
                end else begin
                    w_ptr_nxt   = r_ptr + 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    assign busy = (r_state == c_ST_SWEEP);
    assign ptr  = r_ptr;

endmodule
`default_nettype wire

// File: rtl/cache_line_array.sv
`default_nettype none
// ============================================================================
// Module      : cache_line_array
// Description : Cache line storage with byte-masked writes, per-entry valid
//               and dirty bits, single-entry invalidate, a flush sweep and a
//               running count of valid entries. Reads are combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_line_array
    import lc3b_types::*;
#(
    parameter  int WIDTH = c_WIDTH,
    parameter  int DEPTH = c_DEPTH,
    localparam int IW    = $clog2(DEPTH),
    localparam int NB    = WIDTH / 8,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IW-1:0]    index,
    input  logic             write,
    input  logic [NB-1:0]    wmask,
    input  logic [WIDTH-1:0] datain,
    input  logic             dirty_in,
    input  logic             inval,
    input  logic             flush,
    output logic [WIDTH-1:0] dataout,
    output logic             valid_out,
    output logic             dirty_out,
    output logic             busy,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_dirty;
    logic [CW-1:0]    r_count;

    logic             w_busy;
    logic [IW-1:0]    w_ptr;
    logic             w_do_write;
    logic             w_do_inval;

    array_sweep_ctrl #(
        .DEPTH (DEPTH)
    ) u_sweep (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .busy  (w_busy),
        .ptr   (w_ptr)
    );

    // A sweep in progress or starting this cycle swallows write/inval;
    // write wins over inval when both arrive together.
    assign w_do_write = write & ~w_busy & ~flush;
    assign w_do_inval = inval & ~write & ~w_busy & ~flush;

    // Byte-masked data store; contents intentionally survive reset
    always_ff @(posedge clk) begin
        if (w_do_write) begin
            for (int b = 0; b < NB; b++) begin
                if (wmask[b]) begin
                    r_mem[index][8*b +: 8] <= datain[8*b +: 8];
                end
            end
        end
    end

    // Valid/dirty bits and valid-entry count; sources are mutually exclusive
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_dirty <= '0;
            r_count <= '0;
        end else if (w_do_write) begin
            r_valid[index] <= 1'b1;
            r_dirty[index] <= dirty_in;
            if (!r_valid[index]) begin
                r_count <= r_count + 1'b1;
            end
        end else if (w_do_inval) begin
            r_valid[index] <= 1'b0;
            r_dirty[index] <= 1'b0;
            if (r_valid[index]) begin
                r_count <= r_count - 1'b1;
            end
        end else if (w_busy) begin
            r_valid[w_ptr] <= 1'b0;
            r_dirty[w_ptr] <= 1'b0;
            if (r_valid[w_ptr]) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign dataout   = r_mem[index];
    assign valid_out = r_valid[index] & ~w_busy;
    assign dirty_out = r_dirty[index];
    assign busy      = w_busy;
    assign count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_cache_line_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_line_array
// Description : Directed self-checking bench for cache_line_array with a
//               queue of expected values compared as outputs are sampled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_line_array;
    import lc3b_types::*;

    localparam int W  = c_WIDTH;
    localparam int D  = c_DEPTH;
    localparam int CW = $clog2(D + 1);

    logic            clk = 1'b0;
    logic            rst_n;
    lc3b_index       index;
    logic            write;
    logic [W/8-1:0]  wmask;
    logic [W-1:0]    datain;
    logic            dirty_in;
    logic            inval;
    logic            flush;
    logic [W-1:0]    dataout;
    logic            valid_out;
    logic            dirty_out;
    logic            busy;
    logic [CW-1:0]   count;

    int checks   = 0;
    int failures = 0;
    int nb;

    logic [W-1:0] exp_q [$];
    string        tag_q [$];

    cache_line_array #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .index     (index),
        .write     (write),
        .wmask     (wmask),
        .datain    (datain),
        .dirty_in  (dirty_in),
        .inval     (inval),
        .flush     (flush),
        .dataout   (dataout),
        .valid_out (valid_out),
        .dirty_out (dirty_out),
        .busy      (busy),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic expect_v(input string t, input logic [W-1:0] e);
        tag_q.push_back(t);
        exp_q.push_back(e);
    endtask

    task automatic cmp(input logic [W-1:0] act);
        logic [W-1:0] e;
        string        t;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL sb_underflow: observed=%0h expected=none", act);
            return;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        assert (act === e) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", t, act, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        write    = 1'b0;
        inval    = 1'b0;
        flush    = 1'b0;
        wmask    = '0;
        datain   = '0;
        dirty_in = 1'b0;
    endtask

    task automatic fill_all();
        for (int i = 0; i < D; i++) begin
            index    = lc3b_index'(i);
            write    = 1'b1;
            wmask    = '1;
            datain   = {16{8'(i)}};
            dirty_in = 1'b1;
            tick();
        end
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        index = '0;
        idle();
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        expect_v("rst_count", W'(0));
        expect_v("rst_busy", W'(0));
        cmp(W'(count));
        cmp(W'(busy));
        for (int i = 0; i < D; i++) begin
            index = lc3b_index'(i);
            #1;
            expect_v("rst_valid", W'(0));
            cmp(W'(valid_out));
        end

        // Full write to idx 3; not visible before the edge
        index    = 3'd3;
        write    = 1'b1;
        wmask    = '1;
        datain   = {16{8'hA5}};
        dirty_in = 1'b1;
        #1;
        expect_v("wr3_pre_valid", W'(0));
        cmp(W'(valid_out));
        expect_v("wr3_data", {16{8'hA5}});
        expect_v("wr3_valid", W'(1));
        expect_v("wr3_dirty", W'(1));
        expect_v("wr3_count", W'(1));
        tick();
        idle();
        #1;
        cmp(dataout);
        cmp(W'(valid_out));
        cmp(W'(dirty_out));
        cmp(W'(count));

        // Single-byte write to idx 3
        write    = 1'b1;
        wmask    = 16'h0001;
        datain   = 128'h5A;
        dirty_in = 1'b0;
        expect_v("byte_data", {{15{8'hA5}}, 8'h5A});
        expect_v("byte_dirty", W'(0));
        expect_v("byte_count", W'(1));
        tick();
        idle();
        #1;
        cmp(dataout);
        cmp(W'(dirty_out));
        cmp(W'(count));

        // Zero-mask write to idx 1 still validates
        index    = 3'd1;
        write    = 1'b1;
        wmask    = '0;
        datain   = '1;
        dirty_in = 1'b1;
        expect_v("mask0_valid", W'(1));
        expect_v("mask0_dirty", W'(1));
        expect_v("mask0_count", W'(2));
        tick();
        idle();
        #1;
        cmp(W'(valid_out));
        cmp(W'(dirty_out));
        cmp(W'(count));

        // Invalidate idx 3, then invalidate it again
        index = 3'd3;
        inval = 1'b1;
        expect_v("inval_valid", W'(0));
        expect_v("inval_dirty", W'(0));
        expect_v("inval_count", W'(1));
        expect_v("inval2_count", W'(1));
        tick();
        #1;
        cmp(W'(valid_out));
        cmp(W'(dirty_out));
        cmp(W'(count));
        tick();
        idle();
        #1;
        cmp(W'(count));

        // Zero-mask rewrite of idx 3 shows data untouched by inval
        write = 1'b1;
        wmask = '0;
        expect_v("remask_data", {{15{8'hA5}}, 8'h5A});
        expect_v("remask_valid", W'(1));
        expect_v("remask_count", W'(2));
        tick();
        idle();
        #1;
        cmp(dataout);
        cmp(W'(valid_out));
        cmp(W'(count));

        // Write and inval together on idx 5: write wins
        index  = 3'd5;
        write  = 1'b1;
        inval  = 1'b1;
        wmask  = '1;
        datain = {16{8'h77}};
        expect_v("wrinv_data", {16{8'h77}});
        expect_v("wrinv_valid", W'(1));
        expect_v("wrinv_count", W'(3));
        tick();
        idle();
        #1;
        cmp(dataout);
        cmp(W'(valid_out));
        cmp(W'(count));

        // Fill all entries, then flush
        fill_all();
        index = 3'd6;
        #1;
        expect_v("fill_count", W'(8));
        expect_v("fill_data6", {16{8'h06}});
        cmp(W'(count));
        cmp(dataout);

        index = 3'd0;
        flush = 1'b1;
        tick();
        idle();
        #1;
        nb = 0;
        for (int c = 0; c < 20 && busy; c++) begin
            nb++;
            expect_v("sweep_valid_masked", W'(0));
            cmp(W'(valid_out));
            if (c == 2) begin
                write    = 1'b1;
                wmask    = '1;
                dirty_in = 1'b1;
                flush    = 1'b1;
            end
            tick();
            idle();
            #1;
        end
        expect_v("sweep_cycles", W'(8));
        expect_v("sweep_count", W'(0));
        expect_v("sweep_busy_end", W'(0));
        cmp(W'(nb));
        cmp(W'(count));
        cmp(W'(busy));
        for (int i = 0; i < D; i++) begin
            index = lc3b_index'(i);
            #1;
            expect_v("sweep_valid", W'(0));
            cmp(W'(valid_out));
        end

        // Flush together with write in idle drops the write
        index = 3'd2;
        write = 1'b1;
        wmask = '1;
        tick();
        idle();
        index = 3'd4;
        write = 1'b1;
        flush = 1'b1;
        wmask = '1;
        expect_v("fw_busy", W'(1));
        tick();
        idle();
        #1;
        cmp(W'(busy));
        for (int c = 0; c < 20 && busy; c++) begin
            tick();
        end
        #1;
        expect_v("fw_done", W'(0));
        expect_v("fw_count", W'(0));
        expect_v("fw_valid4", W'(0));
        cmp(W'(busy));
        cmp(W'(count));
        cmp(W'(valid_out));

        // Reset during the 4th sweep cycle
        fill_all();
        flush = 1'b1;
        tick();
        idle();
        tick();
        tick();
        tick();
        #1;
        expect_v("mid_busy", W'(1));
        expect_v("mid_count", W'(5));
        cmp(W'(busy));
        cmp(W'(count));
        rst_n = 1'b0;
        expect_v("rstsw_busy", W'(0));
        expect_v("rstsw_count", W'(0));
        tick();
        rst_n = 1'b1;
        #1;
        cmp(W'(busy));
        cmp(W'(count));
        for (int i = 0; i < D; i++) begin
            index = lc3b_index'(i);
            #1;
            expect_v("rstsw_valid", W'(0));
            cmp(W'(valid_out));
        end
        tick();
        #1;
        expect_v("rstsw_busy_after", W'(0));
        cmp(W'(busy));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
